merge2_arb: RTL and testbench
=============================

Name: merge2_arb

Overview:
- Clocked two-to-one merge stage that sits directly downstream of the 9-bit leaf decoder in the NoC router output path.
- Accepts 9-bit packets from two upstream channels, e.g. Out1 of two neighbouring decoders, and arbitrates between them round-robin.
- Forwards each winning packet on a single output channel.
- Reports the winning input index on a 1-bit grant side channel, the merge-side counterpart of the decoder's S channel.
- Keeps saturating per-input packet counters for debug.

Parameters:
- W, 9, packet width in bits (address in [W-1:W-4]; it is carried, not inspected).
- CW, 8, width of each per-input packet counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in0_valid  in  1  input 0 has a packet.
- in0_data  in  W  input 0 packet.
- in0_ready  out  1  input 0 packet accepted this cycle.
- in1_valid  in  1  input 1 has a packet.
- in1_data  in  W  input 1 packet.
- in1_ready  out  1  input 1 packet accepted this cycle.
- out_valid  out  1  merged packet available.
- out_data  out  W  merged packet.
- out_ready  in  1  downstream accepts the packet.
- g_valid  out  1  grant token available.
- g_data  out  1  index of the input that supplied the current packet.
- g_ready  in  1  grant consumer accepts the token.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt0  out  CW  packets accepted from input 0, saturating.
- cnt1  out  CW  packets accepted from input 1, saturating.

Behaviour:
- Handshake rule: a transfer occurs on any channel when valid and ready are both high at a rising edge.
  - Upstream must hold valid and data stable until ready; the block does not check this.
  - The block holds out_valid/out_data and g_valid/g_data stable until each is accepted.
- Reset (rst_n low, asynchronous), everything takes its reset value immediately:
  - state = IDLE.
  - out_valid = 0, out_data = 0, g_valid = 0, g_data = 0.
  - last_grant = 1, so input 0 wins the first tie.
  - cnt0 = cnt1 = 0.
  - in0_ready = in1_ready = 0.
  - A packet held in SEND at reset is dropped, not replayed.
- State IDLE:
  - Arbitration is combinational.
  - Only in0_valid high: sel = 0. Only in1_valid high: sel = 1.
  - Both high: sel = ~last_grant (round robin).
  - in_sel_ready = 1; the other ready = 0. Neither valid: both ready = 0.
  - On transfer: out_data <= in_sel_data, g_data <= sel, last_grant <= sel, out_pend <= 1, g_pend <= 1, state <= SEND.
- State SEND:
  - in0_ready = in1_ready = 0.
  - out_valid = out_pend and g_valid = g_pend.
  - out_pend clears on the output transfer; g_pend clears on the grant transfer. The two may complete in either order or in the same cycle.
  - When both pend bits are clear after the edge, state <= IDLE.
  - There is no accept in the cycle that returns to IDLE.
- Latency and throughput:
  - A packet accepted at edge N shows out_valid = 1 and g_valid = 1 after edge N.
  - With out_ready = g_ready = 1 constantly, one packet completes every 2 cycles.
- Counters:
  - cntX increments on each input X transfer and saturates at 2^CW-1 (no wrap).
  - cnt_clr forces both counters to 0; clear wins over a same-cycle increment.
- Packet contents are forwarded unmodified; there is no width conversion or reordering.
- Ordering: per input, packets leave in arrival order.

Decomposition:
- Shared noc package holds:
  - packet width constant PKT_W = 9 and address field indices.
  - state enum {IDLE, SEND}.
  - the packet typedef shared with the decoder stages.
- One natural sub-module: rr_arb2. It is combinational 2-input round-robin selection taking valid0, valid1 and last_grant, and producing sel and any_valid.
- Counters are inline; they are small enough not to warrant a module.

Test Plan:
- Reset then single packet: in0 sends 9'h1A5 with out_ready = g_ready = 1.
  - in0_ready pulses for 1 cycle.
  - Next cycle: out_data = 9'h1A5 with out_valid = 1, g_data = 0 with g_valid = 1.
  - cnt0 = 1.
- Simultaneous contention: in0 and in1 held valid for 4 packets each.
  - Grant order is 0,1,0,1,... for 8 packets.
  - cnt0 = cnt1 = 4.
- Independent back-pressure: out_ready = 0 for 3 cycles while g_ready = 1.
  - The grant is consumed at once; out_valid stays high with stable data.
  - No new input is accepted until out_ready rises; then the block returns to IDLE.
- Same-cycle completion vs. staggered completion: both readies high in the same cycle gives the IDLE return in 1 cycle. Grant accepted 2 cycles after data gives the IDLE return after the later transfer.
- Counter saturation and clear:
  - 260 packets on in1 with CW = 8 gives cnt1 = 255.
  - Asserting cnt_clr in the same cycle as an in1 transfer gives cnt1 = 0.
- Reset mid-SEND: assert rst_n = 0 while out_valid = 1.
  - out_valid and g_valid drop immediately.
  - After release, the next tie grants input 0 first.

Source files
------------

// File: rtl/merge2_arb_pkg.sv
// rtl/merge2_arb_pkg.sv - shared NoC packet constants, packet type and merge FSM states
//
// Purpose: constants and types shared between the leaf decoder stages and
//          the two-to-one merge stage.
// Ports:   none (package).

package merge2_arb_pkg;

    // Packet width and address field position (address is carried, never inspected here).
    localparam int PKT_W   = 9;
    localparam int ADDR_HI = PKT_W - 1;
    localparam int ADDR_LO = PKT_W - 4;

    // Packet type shared with the decoder stages.
    typedef logic [PKT_W-1:0] pkt_t;

    // FSM encodings kept as plain constants so older flows can reference them directly.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND
    } state_e;

endpackage

// File: rtl/merge2_arb_rr_arb2.sv
// rtl/merge2_arb_rr_arb2.sv - combinational two-input round-robin selector
//
// Purpose: picks one of two requesters; on a tie the one not granted last wins.
// Ports:
//   valid0, valid1 : request from input 0 / input 1
//   last_grant     : index granted most recently
//   sel            : chosen index (0 when nobody requests)
//   any_valid      : at least one request present

module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic sel,
    output logic any_valid
);

    always_comb begin
        any_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            sel = ~last_grant;
        end else begin
            sel = valid1;
        end
    end

endmodule

// File: rtl/merge2_arb.sv
// rtl/merge2_arb.sv - two-to-one round-robin packet merge with grant side channel
//
// Purpose: merges packets from two upstream channels onto one output, reports
//          the winning input on a 1-bit grant channel and keeps saturating
//          per-input packet counters for debug.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   in0_valid/in0_data/in0_ready    : upstream channel 0
//   in1_valid/in1_data/in1_ready    : upstream channel 1
//   out_valid/out_data/out_ready    : merged packet channel
//   g_valid/g_data/g_ready          : grant token (index of packet source)
//   cnt_clr                         : synchronous clear of both counters
//   cnt0, cnt1                      : saturating accepted-packet counters

module merge2_arb
    import merge2_arb_pkg::*;
#(
    parameter int W  = PKT_W,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in0_valid,
    input  logic [W-1:0]  in0_data,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic [W-1:0]  in1_data,
    output logic          in1_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic          g_valid,
    output logic          g_data,
    input  logic          g_ready,
    input  logic          cnt_clr,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_e        state_q, state_d;
    logic          out_pend_q, out_pend_d;
    logic          g_pend_q, g_pend_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          g_data_q, g_data_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    logic sel;
    logic any_valid;
    logic in0_xfer;
    logic in1_xfer;
    logic accept;

    rr_arb2 u_rr_arb2 (
        .valid0     (in0_valid),
        .valid1     (in1_valid),
        .last_grant (last_grant_q),
        .sel        (sel),
        .any_valid  (any_valid)
    );

    // Ready is offered only to the winner in IDLE. Gating with rst_n keeps both
    // readies low for the whole reset window, not just after the first edge.
    always_comb begin
        accept    = rst_n && (state_q == IDLE) && any_valid;
        in0_ready = accept && !sel;
        in1_ready = accept && sel;
        in0_xfer  = in0_valid && in0_ready;
        in1_xfer  = in1_valid && in1_ready;
    end

    always_comb begin
        state_d      = state_q;
        out_pend_d   = out_pend_q;
        g_pend_d     = g_pend_q;
        out_data_d   = out_data_q;
        g_data_d     = g_data_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    out_data_d   = sel ? in1_data : in0_data;
                    g_data_d     = sel;
                    last_grant_d = sel;
                    out_pend_d   = 1'b1;
                    g_pend_d     = 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                // Output and grant drain independently; leave only once both are gone.
                out_pend_d = out_pend_q && !out_ready;
                g_pend_d   = g_pend_q && !g_ready;
                if (!out_pend_d && !g_pend_d) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clear has priority over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (cnt_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (in0_xfer && (cnt0_q != CNT_MAX)) begin
                cnt0_d = cnt0_q + 1'b1;
            end
            if (in1_xfer && (cnt1_q != CNT_MAX)) begin
                cnt1_d = cnt1_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_pend_q   <= 1'b0;
            g_pend_q     <= 1'b0;
            out_data_q   <= '0;
            g_data_q     <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            out_pend_q   <= out_pend_d;
            g_pend_q     <= g_pend_d;
            out_data_q   <= out_data_d;
            g_data_q     <= g_data_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    always_comb begin
        out_valid = (state_q == SEND) && out_pend_q;
        g_valid   = (state_q == SEND) && g_pend_q;
        out_data  = out_data_q;
        g_data    = g_data_q;
        cnt0      = cnt0_q;
        cnt1      = cnt1_q;
    end

endmodule

// File: tb/tb_merge2_arb.sv
// tb/tb_merge2_arb.sv - directed scoreboard bench for merge2_arb

module tb_merge2_arb;

    localparam int W  = 9;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in0_valid, in1_valid;
    logic [W-1:0]  in0_data, in1_data;
    logic          in0_ready, in1_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          g_valid;
    logic          g_data;
    logic          g_ready;
    logic          cnt_clr;
    logic [CW-1:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] src0_q[$];
    logic [W-1:0] src1_q[$];
    logic [W-1:0] exp_d_q[$];
    logic         exp_g_q[$];

    logic         hold_pend;
    logic [W-1:0] hold_d;

    merge2_arb #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .g_valid   (g_valid),
        .g_data    (g_data),
        .g_ready   (g_ready),
        .cnt_clr   (cnt_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        in0_valid = (src0_q.size() != 0);
        in0_data  = in0_valid ? src0_q[0] : '0;
        in1_valid = (src1_q.size() != 0);
        in1_data  = in1_valid ? src1_q[0] : '0;
    endtask

    task automatic push(input int ch, input logic [W-1:0] d);
        if (ch == 0) src0_q.push_back(d);
        else         src1_q.push_back(d);
    endtask

    task automatic expect_pkt(input logic g, input logic [W-1:0] d);
        exp_g_q.push_back(g);
        exp_d_q.push_back(d);
    endtask

    // One clock: scoreboard work at the falling edge, input updates just after the rising edge.
    task automatic step();
        logic take0, take1;
        logic [W-1:0] ed;
        logic eg;
        @(negedge clk);
        take0 = in0_valid && in0_ready;
        take1 = in1_valid && in1_ready;
        if (hold_pend) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {23'd0, out_data}, {23'd0, hold_d});
        end
        hold_pend = out_valid && !out_ready;
        hold_d    = out_data;
        if (out_valid && out_ready) begin
            if (exp_d_q.size() == 0) begin
                chk("sb_data_underflow", 32'd1, 32'd0);
            end else begin
                ed = exp_d_q.pop_front();
                chk("sb_data", {23'd0, out_data}, {23'd0, ed});
            end
        end
        if (g_valid && g_ready) begin
            if (exp_g_q.size() == 0) begin
                chk("sb_grant_underflow", 32'd1, 32'd0);
            end else begin
                eg = exp_g_q.pop_front();
                chk("sb_grant", {31'd0, g_data}, {31'd0, eg});
            end
        end
        @(posedge clk);
        #1;
        if (take0) void'(src0_q.pop_front());
        if (take1) void'(src1_q.pop_front());
        drive();
    endtask

    task automatic drain(input int limit, output int n);
        n = 0;
        while ((src0_q.size() != 0 || src1_q.size() != 0 ||
                exp_d_q.size() != 0 || exp_g_q.size() != 0) && n < limit) begin
            step();
            n++;
        end
        chk("drain_timeout", {31'd0, (n >= limit)}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        src0_q.delete();
        src1_q.delete();
        exp_d_q.delete();
        exp_g_q.delete();
        hold_pend = 1'b0;
        cnt_clr   = 1'b0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 9'h0AB;
        in1_data  = 9'h0CD;
        #1;
        chk("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
        chk("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_g_valid", {31'd0, g_valid}, 32'd0);
        chk("rst_out_data", {23'd0, out_data}, 32'd0);
        chk("rst_g_data", {31'd0, g_data}, 32'd0);
        chk("rst_cnt0", {24'd0, cnt0}, 32'd0);
        chk("rst_cnt1", {24'd0, cnt1}, 32'd0);
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        g_ready   = 1'b1;
        cnt_clr   = 1'b0;
        hold_pend = 1'b0;
        hold_d    = '0;
        drive();

        // Single packet on input 0.
        do_reset();
        push(0, 9'h1A5);
        expect_pkt(1'b0, 9'h1A5);
        drive();
        #1;
        chk("t1_in0_ready", {31'd0, in0_ready}, 32'd1);
        step();
        chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_out_data", {23'd0, out_data}, 32'h1A5);
        chk("t1_g_valid", {31'd0, g_valid}, 32'd1);
        chk("t1_g_data", {31'd0, g_data}, 32'd0);
        chk("t1_in0_ready_low", {31'd0, in0_ready}, 32'd0);
        chk("t1_cnt0", {24'd0, cnt0}, 32'd1);
        step();
        chk("t1_idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Contention: both inputs loaded with 4 packets, strict alternation from input 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 9'(9'h010 + i));
            push(1, 9'(9'h120 + i));
            expect_pkt(1'b0, 9'(9'h010 + i));
            expect_pkt(1'b1, 9'(9'h120 + i));
        end
        drive();
        drain(100, n);
        chk("t2_cycles", n, 32'd16);
        chk("t2_cnt0", {24'd0, cnt0}, 32'd4);
        chk("t2_cnt1", {24'd0, cnt1}, 32'd4);

        // Output back-pressure while the grant drains immediately.
        do_reset();
        out_ready = 1'b0;
        g_ready   = 1'b1;
        push(0, 9'h0C3);
        push(0, 9'h155);
        expect_pkt(1'b0, 9'h0C3);
        expect_pkt(1'b0, 9'h155);
        drive();
        step();
        chk("t3_g_valid_first", {31'd0, g_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_out_data", {23'd0, out_data}, 32'h0C3);
            chk("t3_g_valid", {31'd0, g_valid}, 32'd0);
            chk("t3_in0_ready", {31'd0, in0_ready}, 32'd0);
            chk("t3_cnt0", {24'd0, cnt0}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("t3_idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_idle_in0_ready", {31'd0, in0_ready}, 32'd1);
        drain(20, n);
        chk("t3_cnt0_end", {24'd0, cnt0}, 32'd2);

        // Same-cycle completion, then staggered completion.
        do_reset();
        push(1, 9'h0AA);
        expect_pkt(1'b1, 9'h0AA);
        drive();
        step();
        step();
        chk("t4_same_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_same_g_valid", {31'd0, g_valid}, 32'd0);
        g_ready = 1'b0;
        push(1, 9'h1F0);
        push(1, 9'h055);
        expect_pkt(1'b1, 9'h1F0);
        expect_pkt(1'b1, 9'h055);
        drive();
        step();
        step();
        chk("t4_stag_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_stag_g_valid", {31'd0, g_valid}, 32'd1);
        chk("t4_stag_in1_ready", {31'd0, in1_ready}, 32'd0);
        step();
        chk("t4_stag_g_hold", {31'd0, g_valid}, 32'd1);
        chk("t4_stag_g_data", {31'd0, g_data}, 32'd1);
        g_ready = 1'b1;
        step();
        chk("t4_stag_g_done", {31'd0, g_valid}, 32'd0);
        chk("t4_stag_idle_rdy", {31'd0, in1_ready}, 32'd1);
        drain(20, n);

        // Counter saturation, then clear against a same-cycle increment.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            push(1, 9'(i));
            expect_pkt(1'b1, 9'(i));
        end
        drive();
        drain(600, n);
        chk("t5_cnt1_sat", {24'd0, cnt1}, 32'd255);
        chk("t5_cnt0", {24'd0, cnt0}, 32'd0);
        push(1, 9'h1EE);
        expect_pkt(1'b1, 9'h1EE);
        drive();
        cnt_clr = 1'b1;
        #1;
        chk("t5_clr_in1_ready", {31'd0, in1_ready}, 32'd1);
        step();
        cnt_clr = 1'b0;
        chk("t5_cnt1_clr", {24'd0, cnt1}, 32'd0);
        drain(20, n);
        push(1, 9'h033);
        expect_pkt(1'b1, 9'h033);
        drive();
        drain(20, n);
        chk("t5_cnt1_after", {24'd0, cnt1}, 32'd1);

        // Reset while a packet is held; it must be dropped and the tie must restart at input 0.
        out_ready = 1'b0;
        g_ready   = 1'b0;
        push(0, 9'h111);
        drive();
        step();
        chk("t6_out_valid_pre", {31'd0, out_valid}, 32'd1);
        chk("t6_g_valid_pre", {31'd0, g_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid_rst", {31'd0, out_valid}, 32'd0);
        chk("t6_g_valid_rst", {31'd0, g_valid}, 32'd0);
        src0_q.delete();
        hold_pend = 1'b0;
        drive();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        g_ready   = 1'b1;
        @(posedge clk);
        #1;
        push(0, 9'h0F0);
        push(1, 9'h10F);
        expect_pkt(1'b0, 9'h0F0);
        expect_pkt(1'b1, 9'h10F);
        drive();
        #1;
        chk("t6_tie_in0_ready", {31'd0, in0_ready}, 32'd1);
        chk("t6_tie_in1_ready", {31'd0, in1_ready}, 32'd0);
        drain(20, n);
        chk("t6_cnt0", {24'd0, cnt0}, 32'd1);
        chk("t6_cnt1", {24'd0, cnt1}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
